// File: rtl/except_ctrl_if.sv
// +----------------------------------------------------------------------+
// | except_ctrl_if : MEM-stage / CP0 bus seen by the exception controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface except_ctrl_if;
  logic        mem_valid_i;
  logic [4:0]  except_flags_i;
  logic [31:0] cur_inst_addr_i;
  logic        in_delayslot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] except_type_o;
  logic [31:0] cur_inst_addr_o;
  logic        in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] epc_o;

  modport master (
    output mem_valid_i, except_flags_i, cur_inst_addr_i, in_delayslot_i,
           status_i, cause_i, epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    input  except_type_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o, epc_o
  );

  modport slave (
    input  mem_valid_i, except_flags_i, cur_inst_addr_i, in_delayslot_i,
           status_i, cause_i, epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    output except_type_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o, epc_o
  );
endinterface

`default_nettype wire

// File: rtl/except_ctrl.sv
// +----------------------------------------------------------------------+
// | except_ctrl : MEM-stage exception arbiter, CP0 forwarding, flush FSM |
// | Optional macro EXCEPT_STATS_EN adds exc_count_o.  Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_sync_o,
`ifdef EXCEPT_STATS_EN
  output logic [31:0] exc_count_o,
`endif
  except_ctrl_if.slave bus
);

  localparam logic [31:0] c_code_none = 32'h0;
  localparam logic [31:0] c_code_int  = 32'h1;
  localparam logic [31:0] c_code_sys  = 32'h8;
  localparam logic [31:0] c_code_inv  = 32'ha;
  localparam logic [31:0] c_code_ovf  = 32'hc;
  localparam logic [31:0] c_code_trap = 32'hd;
  localparam logic [31:0] c_code_eret = 32'he;
  localparam int unsigned c_sync_w    = SYNC_STAGES * 6;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

  // Synchronizer chain: newest sample in the low six bits.
  logic [c_sync_w-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[c_sync_w-7:0], int_i};
    end
  end

  assign int_sync_o = sync_q[c_sync_w-1 -: 6];

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;

  // Cause is only partially software-writable: IP1:0, IV and WP.
  always_comb begin
    status_eff = bus.status_i;
    cause_eff  = bus.cause_i;
    epc_eff    = bus.epc_i;
    if (bus.wb_cp0_we_i) begin
      case (bus.wb_cp0_waddr_i)
        5'd12: status_eff = bus.wb_cp0_wdata_i;
        5'd13: begin
          cause_eff[9:8] = bus.wb_cp0_wdata_i[9:8];
          cause_eff[22]  = bus.wb_cp0_wdata_i[22];
          cause_eff[23]  = bus.wb_cp0_wdata_i[23];
        end
        5'd14: epc_eff = bus.wb_cp0_wdata_i;
        default: ;
      endcase
    end
  end

  assign bus.epc_o = epc_eff;

  logic int_pending;
  logic unused_fwd;

  assign int_pending = (|(cause_eff[15:8] & status_eff[15:8])) &
                       status_eff[0] & ~status_eff[1];
  assign unused_fwd  = ^{status_eff[31:16], status_eff[7:2],
                         cause_eff[31:16], cause_eff[7:0]};

  logic [31:0] code;

  always_comb begin
    code = c_code_none;
    if (bus.mem_valid_i) begin
      if (int_pending)                 code = c_code_int;
      else if (bus.except_flags_i[2])  code = c_code_inv;
      else if (bus.except_flags_i[1])  code = c_code_trap;
      else if (bus.except_flags_i[0])  code = c_code_ovf;
      else if (bus.except_flags_i[3])  code = c_code_sys;
      else if (bus.except_flags_i[4])  code = c_code_eret;
      else                             code = c_code_none;
    end
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] except_type_q, except_type_d;
  logic [31:0] cur_inst_addr_q, cur_inst_addr_d;
  logic        in_delayslot_q, in_delayslot_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        take_event;

  assign take_event = (state_q == S_IDLE) && (code != c_code_none);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      except_type_q   <= '0;
      cur_inst_addr_q <= '0;
      in_delayslot_q  <= 1'b0;
      flush_q         <= 1'b0;
      new_pc_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      except_type_q   <= except_type_d;
      cur_inst_addr_q <= cur_inst_addr_d;
      in_delayslot_q  <= in_delayslot_d;
      flush_q         <= flush_d;
      new_pc_q        <= new_pc_d;
    end
  end

  // The CP0 handoff fields are one-cycle pulses; flush/new_pc persist.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    except_type_d   = '0;
    cur_inst_addr_d = '0;
    in_delayslot_d  = 1'b0;
    flush_d         = flush_q;
    new_pc_d        = new_pc_q;
    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (take_event) begin
          except_type_d   = code;
          cur_inst_addr_d = bus.cur_inst_addr_i;
          in_delayslot_d  = bus.in_delayslot_i;
          flush_d         = 1'b1;
          new_pc_d        = (code == c_code_eret) ? epc_eff : EXC_VECTOR;
          cnt_d           = 4'(FLUSH_CYCLES - 1);
          state_d         = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.except_type_o   = except_type_q;
  assign bus.cur_inst_addr_o = cur_inst_addr_q;
  assign bus.in_delayslot_o  = in_delayslot_q;
  assign bus.flush_o         = flush_q;
  assign bus.new_pc_o        = new_pc_q;

`ifdef EXCEPT_STATS_EN
  logic [31:0] exc_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_count_q <= '0;
    end else if (take_event && (code != c_code_eret) && (exc_count_q != 32'hFFFF_FFFF)) begin
      exc_count_q <= exc_count_q + 32'd1;
    end
  end

  assign exc_count_o = exc_count_q;
`else
  // Event statistics are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_except_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_except_ctrl : directed scoreboard bench for except_ctrl           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_except_ctrl;
  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [5:0]  int_sync;
`ifdef EXCEPT_STATS_EN
  logic [31:0] exc_count;
`endif

  except_ctrl_if bus ();

  except_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .FLUSH_CYCLES (FC),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .int_i       (int_i),
    .int_sync_o  (int_sync),
`ifdef EXCEPT_STATS_EN
    .exc_count_o (exc_count),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] et;
    logic [31:0] pc;
    logic        ds;
    logic        fl;
    logic [31:0] npc;
    logic        cn;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                      input logic fl, input logic [31:0] npc, input logic cn);
    exp_t e;
    e.et = et; e.pc = pc; e.ds = ds; e.fl = fl; e.npc = npc; e.cn = cn;
    sbq.push_back(e);
    if (et != 32'h0 && et != 32'he) model_cnt++;
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".type"},  bus.except_type_o, e.et);
      chk({tag, ".pc"},    bus.cur_inst_addr_o, e.pc);
      chk({tag, ".ds"},    {31'd0, bus.in_delayslot_o}, {31'd0, e.ds});
      chk({tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, e.fl});
      if (e.cn) chk({tag, ".newpc"}, bus.new_pc_o, e.npc);
    end
  endtask

  task automatic idle();
    bus.mem_valid_i     = 1'b0;
    bus.except_flags_i  = 5'd0;
    bus.cur_inst_addr_i = 32'd0;
    bus.in_delayslot_i  = 1'b0;
    bus.status_i        = 32'd0;
    bus.cause_i         = 32'd0;
    bus.epc_i           = 32'd0;
    bus.wb_cp0_we_i     = 1'b0;
    bus.wb_cp0_waddr_i  = 5'd0;
    bus.wb_cp0_wdata_i  = 32'd0;
  endtask

  task automatic flush_tail(input string tag, input logic [31:0] npc);
    idle();
    for (int i = 1; i < FC; i++) begin
      push(32'h0, 32'h0, 1'b0, 1'b1, npc, 1'b1);
      step({tag, ".hold"});
    end
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step({tag, ".exit"});
  endtask

  initial begin
    rst   = 1'b1;
    int_i = 6'd0;
    idle();
    #1;
    chk("rst.type",  bus.except_type_o, 32'h0);
    chk("rst.pc",    bus.cur_inst_addr_o, 32'h0);
    chk("rst.flush", {31'd0, bus.flush_o}, 32'h0);
    chk("rst.newpc", bus.new_pc_o, 32'h0);
    chk("rst.sync",  {26'd0, int_sync}, 32'h0);
`ifdef EXCEPT_STATS_EN
    chk("rst.count", exc_count, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Interrupt taken
    bus.status_i = 32'h1000_0401; bus.cause_i = 32'h0000_0400;
    bus.mem_valid_i = 1'b1; bus.cur_inst_addr_i = 32'h100;
    push(32'h1, 32'h100, 1'b0, 1'b1, 32'h20, 1'b1);
    step("irq");
    flush_tail("irq", 32'h20);

    // Priority with EXL masking the pending interrupt
    bus.status_i = 32'h1000_0403; bus.cause_i = 32'h0000_0400;
    bus.mem_valid_i = 1'b1; bus.except_flags_i = 5'b01101;
    bus.cur_inst_addr_i = 32'h104; bus.in_delayslot_i = 1'b1;
    push(32'ha, 32'h104, 1'b1, 1'b1, 32'h20, 1'b1);
    step("prio");
    flush_tail("prio", 32'h20);

    bus.status_i = 32'h1000_0403; bus.cause_i = 32'h0000_0400; bus.mem_valid_i = 1'b1;
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("exl_mask");

    // mem_valid low masks interrupt and flags
    bus.status_i = 32'h401; bus.cause_i = 32'h400; bus.except_flags_i = 5'b00100;
    bus.mem_valid_i = 1'b0;
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("novalid");

    // Same-cycle WB write of EXL=1 suppresses the interrupt
    idle();
    bus.status_i = 32'h401; bus.cause_i = 32'h400; bus.mem_valid_i = 1'b1;
    bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd12; bus.wb_cp0_wdata_i = 32'h403;
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("wb_exl");

    // Cause forwarding: bit 10 is not writable, bit 8 is
    idle();
    bus.status_i = 32'h501; bus.mem_valid_i = 1'b1; bus.cur_inst_addr_i = 32'h108;
    bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd13; bus.wb_cp0_wdata_i = 32'h400;
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("cause_ro");
    bus.wb_cp0_wdata_i = 32'h500;
    push(32'h1, 32'h108, 1'b0, 1'b1, 32'h20, 1'b1);
    step("cause_fwd");
    flush_tail("cause_fwd", 32'h20);

    // ERET with forwarded EPC
    bus.epc_i = 32'h200;
    #1 chk("epc_plain", bus.epc_o, 32'h200);
    bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_wdata_i = 32'h300;
    bus.except_flags_i = 5'b10000; bus.mem_valid_i = 1'b1; bus.cur_inst_addr_i = 32'h10c;
    #1 chk("epc_fwd", bus.epc_o, 32'h300);
    push(32'he, 32'h10c, 1'b0, 1'b1, 32'h300, 1'b1);
    step("eret");
    flush_tail("eret", 32'h300);

    // Flush hold: syscall held through FLUSH is taken only after IDLE
    bus.mem_valid_i = 1'b1; bus.except_flags_i = 5'b00001; bus.cur_inst_addr_i = 32'h400;
    push(32'hc, 32'h400, 1'b0, 1'b1, 32'h20, 1'b1);
    step("ovf");
    bus.except_flags_i = 5'b01000; bus.cur_inst_addr_i = 32'h500;
    push(32'h0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b1);
    step("ovf.hold1");
    push(32'h0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b1);
    step("ovf.hold2");
    push(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("ovf.exit");
    push(32'h8, 32'h500, 1'b0, 1'b1, 32'h20, 1'b1);
    step("sys");
    flush_tail("sys", 32'h20);

    // Synchronizer latency and single-cycle pulse propagation
    int_i = 6'b000001;
    @(posedge clk); #1 chk("sync.1edge", {26'd0, int_sync}, 32'h0);
    int_i = 6'b100000;
    @(posedge clk); #1 chk("sync.2edge", {26'd0, int_sync}, 32'h1);
    int_i = 6'b000000;
    @(posedge clk); #1 chk("sync.pulse", {26'd0, int_sync}, 32'h20);
    @(posedge clk); #1 chk("sync.clear", {26'd0, int_sync}, 32'h0);

`ifdef EXCEPT_STATS_EN
    chk("count", exc_count, model_cnt);
`endif

    // Reset mid-FLUSH
    bus.mem_valid_i = 1'b1; bus.except_flags_i = 5'b00001; bus.cur_inst_addr_i = 32'h600;
    push(32'hc, 32'h600, 1'b0, 1'b1, 32'h20, 1'b1);
    step("pre_rst");
    idle();
    int_i = 6'b000011;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    model_cnt = 0;
    chk("midrst.flush", {31'd0, bus.flush_o}, 32'h0);
    chk("midrst.newpc", bus.new_pc_o, 32'h0);
    chk("midrst.sync",  {26'd0, int_sync}, 32'h0);
`ifdef EXCEPT_STATS_EN
    chk("midrst.count", exc_count, 32'h0);
`endif
    int_i = 6'd0;
    @(posedge clk);
    #2 rst = 1'b0;

    bus.mem_valid_i = 1'b1; bus.except_flags_i = 5'b01000; bus.cur_inst_addr_i = 32'h700;
    push(32'h8, 32'h700, 1'b0, 1'b1, 32'h20, 1'b1);
    step("post_rst");
    flush_tail("post_rst", 32'h20);
`ifdef EXCEPT_STATS_EN
    chk("count.post", exc_count, model_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish by 50000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
